// File: rtl/sdram_sched.sv
`timescale 1ns/1ps
// SDRAM command scheduler: boot copy from the video source, then CPU accesses and refreshes.
// Latency: one command in flight; CPU ack one cycle after sdrDone, or after TMO cycles on timeout.
// Backpressure: a command waits for sdrDone; CPU and refresh requests queue as single pending flags.
module sdram_sched #(
    parameter int BOOTN = 16384,
    parameter int RFPER = 390,
    parameter int TMO   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [23:0] cpuA,
    input  logic [7:0]  cpuD,
    output logic [7:0]  cpuQ,
    output logic        cpuAck,
    input  logic        rfReq,
    output logic [15:0] bootA,
    input  logic [7:0]  bootQ,
    output logic        bootDone,
    output logic        sdrRd,
    output logic        sdrWr,
    output logic        sdrRf,
    output logic [23:0] sdrA,
    output logic [15:0] sdrD,
    input  logic [15:0] sdrQ,
    input  logic        sdrDone,
    output logic        err
);

    typedef enum logic [2:0] {WRDY, BRD, BWR, BWT, BRF, IDLE, CPU, RF} state_t;

    localparam int RW = (RFPER > 2) ? $clog2(RFPER) : 1;
    localparam int WW = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [15:0]   LASTA   = 16'(BOOTN - 1);
    localparam logic [RW-1:0] RFLAST  = RW'(RFPER - 1);
    localparam logic [WW-1:0] TMOLAST = WW'(TMO - 1);

    state_t        state;
    state_t        stateNext;
    logic [RW-1:0] rfCnt;
    logic          rfDue;
    logic [WW-1:0] waitCnt;
    logic          rfPend;
    logic          cpuPend;
    logic          cpuReqQ;
    logic [23:0]   cpuALat;
    logic [7:0]    cpuDLat;
    logic          cpuWeLat;
    logic          cpuRd;

    logic goRd;
    logic goWr;
    logic goRf;
    logic inWait;
    logic timedOut;
    logic waitHit;
    logic bootPhase;
    logic cpuStart;
    logic cpuIssue;
    logic unusedSdrQHi;

    assign bootPhase    = (state == BRD) || (state == BWR) || (state == BWT) || (state == BRF);
    assign cpuStart     = bootDone && cpuReq && !cpuReqQ;
    assign cpuIssue     = (state == IDLE) && (goRd || goWr);
    assign unusedSdrQHi = ^sdrQ[15:8];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WRDY;
        end else begin
            state <= stateNext;
        end
    end

    // Strobes are registered from goRd/goWr/goRf so each lands on entry to its wait state.
    always_comb begin
        stateNext = state;
        goRd      = 1'b0;
        goWr      = 1'b0;
        goRf      = 1'b0;
        inWait    = (state == BWT) || (state == BRF) || (state == CPU) || (state == RF);
        timedOut  = inWait && !sdrDone && (waitCnt == TMOLAST);
        waitHit   = inWait && (sdrDone || timedOut);
        case (state)
            WRDY: begin
                if (ready) stateNext = BRD;
            end
            BRD: begin
                stateNext = BWR;
            end
            BWR: begin
                stateNext = BWT;
                goWr      = 1'b1;
            end
            BWT: begin
                if (waitHit) begin
                    if (bootA == LASTA) begin
                        stateNext = IDLE;
                    end else if (rfDue) begin
                        stateNext = BRF;
                        goRf      = 1'b1;
                    end else begin
                        stateNext = BRD;
                    end
                end
            end
            BRF: begin
                if (waitHit) stateNext = BRD;
            end
            IDLE: begin
                if (rfPend) begin
                    stateNext = RF;
                    goRf      = 1'b1;
                end else if (cpuPend) begin
                    stateNext = CPU;
                    goWr      = cpuWeLat;
                    goRd      = !cpuWeLat;
                end
            end
            CPU, RF: begin
                if (waitHit) stateNext = IDLE;
            end
            default: stateNext = WRDY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sdrRd    <= 1'b0;
            sdrWr    <= 1'b0;
            sdrRf    <= 1'b0;
            cpuAck   <= 1'b0;
            bootDone <= 1'b0;
            err      <= 1'b0;
            cpuQ     <= 8'hFF;
            bootA    <= 16'd0;
            sdrA     <= 24'd0;
            sdrD     <= 16'd0;
            rfCnt    <= '0;
            rfDue    <= 1'b0;
            waitCnt  <= '0;
            rfPend   <= 1'b0;
            cpuPend  <= 1'b0;
            cpuReqQ  <= 1'b0;
            cpuALat  <= 24'd0;
            cpuDLat  <= 8'd0;
            cpuWeLat <= 1'b0;
            cpuRd    <= 1'b0;
        end else begin
            sdrRd   <= goRd;
            sdrWr   <= goWr;
            sdrRf   <= goRf;
            cpuAck  <= 1'b0;
            cpuReqQ <= cpuReq;

            if (goRd || goWr || goRf) begin
                waitCnt <= '0;
            end else if (inWait && waitCnt != TMOLAST) begin
                waitCnt <= waitCnt + WW'(1);
            end
            if (timedOut) err <= 1'b1;

            if (state == BWR) begin
                sdrA <= {8'h00, bootA};
                sdrD <= {bootQ, bootQ};
            end
            // bootA stops at the last address so it stays valid after the copy.
            if (state == BWT && waitHit) begin
                if (bootA == LASTA) begin
                    bootDone <= 1'b1;
                end else begin
                    bootA <= bootA + 16'd1;
                end
            end

            if (state == BWT && goRf) begin
                rfCnt <= '0;
                rfDue <= 1'b0;
            end else if (bootPhase) begin
                if (rfCnt == RFLAST) begin
                    rfDue <= 1'b1;
                end else begin
                    rfCnt <= rfCnt + RW'(1);
                end
            end

            // A request seen in the issue cycle is folded into the refresh being issued.
            if (bootDone && rfReq) rfPend <= 1'b1;
            if (state == IDLE && goRf) rfPend <= 1'b0;

            if (cpuIssue) begin
                sdrA    <= cpuALat;
                sdrD    <= {cpuDLat, cpuDLat};
                cpuRd   <= goRd;
                cpuPend <= 1'b0;
            end
            if (cpuStart && (!cpuPend || cpuIssue)) begin
                cpuALat  <= cpuA;
                cpuDLat  <= cpuD;
                cpuWeLat <= cpuWe;
                cpuPend  <= 1'b1;
            end

            if (state == CPU && waitHit) begin
                cpuAck <= 1'b1;
                if (cpuRd) cpuQ <= timedOut ? 8'hFF : sdrQ[7:0];
            end
        end
    end

endmodule

// File: tb/tb_sdram_sched.sv
`timescale 1ns/1ps
// Directed bench for sdram_sched: boot copy with refresh interleave, CPU access,
// refresh collapsing, timeout and mid-boot reset.
module tb_sdram_sched;
    localparam int BOOTN = 4;
    localparam int RFPER = 8;
    localparam int TMO   = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic        cpuReq;
    logic        cpuWe;
    logic [23:0] cpuA;
    logic [7:0]  cpuD;
    logic [7:0]  cpuQ;
    logic        cpuAck;
    logic        rfReq;
    logic [15:0] bootA;
    logic [7:0]  bootQ = 8'h00;
    logic        bootDone;
    logic        sdrRd;
    logic        sdrWr;
    logic        sdrRf;
    logic [23:0] sdrA;
    logic [15:0] sdrD;
    logic [15:0] sdrQ;
    logic        sdrDone = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int logKind[$];
    logic [23:0] logAddr[$];
    logic [15:0] logData[$];
    int logCyc[$];
    int multiStrobe = 0;
    int ackCount = 0;
    int ackCyc = 0;
    int doneDly = 3;
    bit doneEn = 1'b1;
    bit spurious = 1'b0;
    int rem = 0;

    sdram_sched #(.BOOTN(BOOTN), .RFPER(RFPER), .TMO(TMO)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuD(cpuD),
        .cpuQ(cpuQ), .cpuAck(cpuAck), .rfReq(rfReq),
        .bootA(bootA), .bootQ(bootQ), .bootDone(bootDone),
        .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrRf(sdrRf),
        .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ), .sdrDone(sdrDone), .err(err)
    );

    always #5 clock = ~clock;

    // Registered boot source: data for the address presented in the previous cycle.
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        bootQ <= 8'hA0 + bootA[7:0];
    end

    // Strobe logger plus SDRAM controller model answering doneDly cycles after a strobe.
    always @(negedge clock) begin
        int n;
        n = 0;
        if (sdrRd === 1'b1) begin
            n++; logKind.push_back(0); logAddr.push_back(sdrA); logData.push_back(sdrD); logCyc.push_back(cyc);
        end
        if (sdrWr === 1'b1) begin
            n++; logKind.push_back(1); logAddr.push_back(sdrA); logData.push_back(sdrD); logCyc.push_back(cyc);
        end
        if (sdrRf === 1'b1) begin
            n++; logKind.push_back(2); logAddr.push_back(sdrA); logData.push_back(sdrD); logCyc.push_back(cyc);
        end
        if (n > 1) multiStrobe++;
        if (cpuAck === 1'b1) begin
            ackCount++;
            ackCyc = cyc;
        end
        if (reset === 1'b1) begin
            rem = 0;
            sdrDone = 1'b0;
        end else begin
            sdrDone = spurious;
            if (rem > 0) begin
                rem--;
                if (rem == 0 && doneEn) sdrDone = 1'b1;
            end
            if (n > 0) rem = doneDly;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic waitLog(input int target, input int budget, input string tag);
        int k = 0;
        while (logKind.size() < target && k < budget) begin
            step(1);
            k++;
        end
        check(tag, (logKind.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic waitAck(input int target, input int budget, input string tag);
        int k = 0;
        while (ackCount < target && k < budget) begin
            step(1);
            k++;
        end
        check(tag, (ackCount >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic waitBoot(input int budget, input string tag);
        int k = 0;
        while (bootDone !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(bootDone), 32'd1);
    endtask

    initial begin
        int base;
        int acks;
        int k;
        int wrIdx;
        int nrf;
        int rfBefore;
        int rdSeen;
        int dly;
        bit found;
        logic [7:0] b;

        reset = 1'b1; ready = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0;
        cpuA = 24'd0; cpuD = 8'd0; rfReq = 1'b0; sdrQ = 16'h5A5A;
        step(2);
        check("rst_flags", 32'({sdrRd, sdrWr, sdrRf, cpuAck, bootDone, err}), 32'd0);
        check("rst_cpuQ", 32'(cpuQ), 32'hFF);
        check("rst_bootA", 32'(bootA), 32'd0);
        check("rst_sdrA", 32'(sdrA), 32'd0);
        check("rst_sdrD", 32'(sdrD), 32'd0);

        // WRDY holds while ready is low
        reset = 1'b0;
        step(4);
        check("wrdy_no_strobe", 32'(logKind.size()), 32'd0);
        check("wrdy_bootA", 32'(bootA), 32'd0);

        // Boot copy; requests during boot must be dropped
        ready = 1'b1;
        step(5);
        rfReq = 1'b1; cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 24'h000055;
        step(1);
        rfReq = 1'b0; cpuReq = 1'b0;
        waitBoot(400, "boot_timeout");
        wrIdx = 0; nrf = 0; rfBefore = 0; rdSeen = 0;
        for (int i = 0; i < logKind.size(); i++) begin
            if (logKind[i] == 1) begin
                b = 8'hA0 + 8'(wrIdx);
                check("boot_wr_addr", 32'(logAddr[i]), 32'(wrIdx));
                check("boot_wr_data", 32'(logData[i]), 32'({b, b}));
                wrIdx++;
            end else if (logKind[i] == 2) begin
                nrf++;
                if (wrIdx < BOOTN) rfBefore++;
            end else begin
                rdSeen++;
            end
        end
        check("boot_wr_count", 32'(wrIdx), 32'(BOOTN));
        check("boot_rf_interleaved", (rfBefore > 0) ? 32'd1 : 32'd0, 32'd1);
        check("boot_no_rd", 32'(rdSeen), 32'd0);

        base = logKind.size();
        step(10);
        check("boot_reqs_dropped", 32'(logKind.size()), 32'(base));
        check("boot_no_ack", 32'(ackCount), 32'd0);
        check("bootA_final", 32'(bootA), 32'(BOOTN - 1));

        // Unsolicited sdrDone in IDLE is ignored
        spurious = 1'b1;
        step(1);
        spurious = 1'b0;
        step(3);
        check("spurious_no_strobe", 32'(logKind.size()), 32'(base));
        check("spurious_no_ack", 32'(ackCount), 32'd0);
        check("spurious_no_err", 32'(err), 32'd0);

        // CPU read, cpuReq held for 20 cycles
        base = logKind.size(); acks = ackCount;
        cpuWe = 1'b0; cpuA = 24'h012345; cpuD = 8'h11; cpuReq = 1'b1;
        step(20);
        check("rd_one_access", 32'(logKind.size() - base), 32'd1);
        if (logKind.size() > base) begin
            check("rd_kind", 32'(logKind[base]), 32'd0);
            check("rd_addr", 32'(logAddr[base]), 32'h012345);
        end
        check("rd_ack_once", 32'(ackCount - acks), 32'd1);
        check("rd_cpuQ", 32'(cpuQ), 32'h5A);
        cpuReq = 1'b0;
        step(2);

        // CPU write leaves cpuQ alone
        base = logKind.size(); acks = ackCount;
        cpuWe = 1'b1; cpuA = 24'hABCDEF; cpuD = 8'h3C; sdrQ = 16'h1234; cpuReq = 1'b1;
        step(12);
        check("wr_one_access", 32'(logKind.size() - base), 32'd1);
        if (logKind.size() > base) begin
            check("wr_kind", 32'(logKind[base]), 32'd1);
            check("wr_addr", 32'(logAddr[base]), 32'hABCDEF);
            check("wr_data", 32'(logData[base]), 32'h3C3C);
        end
        check("wr_ack_once", 32'(ackCount - acks), 32'd1);
        check("wr_cpuQ_kept", 32'(cpuQ), 32'h5A);
        cpuReq = 1'b0; sdrQ = 16'h5A5A;
        step(2);

        // Refresh and CPU edge in the same cycle: refresh first
        base = logKind.size(); acks = ackCount;
        rfReq = 1'b1; cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 24'h000777;
        step(1);
        rfReq = 1'b0;
        waitLog(base + 2, 40, "prio_timeout");
        step(6);
        if (logKind.size() >= base + 2) begin
            check("prio_first_rf", 32'(logKind[base]), 32'd2);
            check("prio_then_rd", 32'(logKind[base + 1]), 32'd0);
            check("prio_rd_addr", 32'(logAddr[base + 1]), 32'h000777);
            check("prio_gap", 32'(logCyc[base + 1] - logCyc[base]), 32'd5);
        end
        check("prio_ack", 32'(ackCount - acks), 32'd1);
        cpuReq = 1'b0;
        step(3);

        // Three rfReq pulses inside a refresh collapse to one more refresh
        base = logKind.size();
        doneDly = 6;
        rfReq = 1'b1;
        step(1);
        rfReq = 1'b0;
        waitLog(base + 1, 20, "rf_timeout");
        for (int p = 0; p < 3; p++) begin
            rfReq = 1'b1;
            step(1);
            rfReq = 1'b0;
            step(1);
        end
        step(40);
        nrf = 0;
        for (int i = base; i < logKind.size(); i++) if (logKind[i] == 2) nrf++;
        check("rf_collapse_count", 32'(nrf), 32'd2);
        check("rf_collapse_total", 32'(logKind.size() - base), 32'd2);
        doneDly = 3;

        // Withheld sdrDone on a CPU read
        check("tmo_err_before", 32'(err), 32'd0);
        base = logKind.size(); acks = ackCount;
        doneEn = 1'b0;
        cpuWe = 1'b0; cpuA = 24'h000100; cpuReq = 1'b1;
        waitAck(acks + 1, 60, "tmo_ack_timeout");
        step(1);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_cpuQ", 32'(cpuQ), 32'hFF);
        check("tmo_ack_once", 32'(ackCount - acks), 32'd1);
        if (logKind.size() > base) begin
            check("tmo_rd_addr", 32'(logAddr[base]), 32'h000100);
            dly = ackCyc - logCyc[base];
            check("tmo_delay", (dly >= TMO && dly <= TMO + 2) ? 32'd1 : 32'd0, 32'd1);
        end
        cpuReq = 1'b0; doneEn = 1'b1;
        step(3);

        // Reset in BWT at bootA=2, then restart from 0
        reset = 1'b1; ready = 1'b0;
        step(2);
        reset = 1'b0; ready = 1'b1;
        base = logKind.size();
        found = 1'b0; k = 0;
        while (!found && k < 200) begin
            step(1);
            k++;
            if (logKind.size() > base && logKind[$] == 1 && logAddr[$] == 24'd2) found = 1'b1;
        end
        check("mid_reach_bwt2", 32'(found), 32'd1);
        reset = 1'b1; ready = 1'b0;
        step(1);
        check("mid_strobes", 32'({sdrRd, sdrWr, sdrRf, cpuAck}), 32'd0);
        check("mid_flags", 32'({bootDone, err}), 32'd0);
        check("mid_bootA", 32'(bootA), 32'd0);
        check("mid_sdrA", 32'(sdrA), 32'd0);
        check("mid_cpuQ", 32'(cpuQ), 32'hFF);
        base = logKind.size();
        step(3);
        reset = 1'b0;
        step(4);
        check("mid_no_strobe", 32'(logKind.size()), 32'(base));
        ready = 1'b1;
        waitLog(base + 1, 20, "mid_restart_timeout");
        if (logKind.size() > base) begin
            check("mid_restart_kind", 32'(logKind[base]), 32'd1);
            check("mid_restart_addr", 32'(logAddr[base]), 32'd0);
            check("mid_restart_data", 32'(logData[base]), 32'hA0A0);
        end
        waitBoot(400, "mid_reboot_timeout");
        check("mid_reboot_bootA", 32'(bootA), 32'(BOOTN - 1));

        check("one_hot_strobes", 32'(multiStrobe), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_sched.md
SDRAM_SCHED -- requirements
Module: sdram_sched

Interface
REQ-001 Parameter BOOTN, default 16384: number of bytes the boot copy writes.
REQ-002 Parameter RFPER, default 390: boot-phase refresh interval in clock cycles.
REQ-003 Parameter TMO, default 15: cycles to wait for sdrDone before a timeout.
REQ-004 Port clock, in, 1: the single clock; all logic is rising-edge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port ready, in, 1: SDRAM controller initialisation complete.
REQ-007 Port cpuReq, in, 1: CPU access request, level-sensitive.
REQ-008 Port cpuWe, in, 1: CPU access is a write (1) or a read (0).
REQ-009 Port cpuA, in, 24: CPU byte address.
REQ-010 Port cpuD, in, 8: CPU write data.
REQ-011 Port cpuQ, out, 8: CPU read data.
REQ-012 Port cpuAck, out, 1: one-cycle CPU completion pulse.
REQ-013 Port rfReq, in, 1: refresh request strobe from the CPU refresh cycle.
REQ-014 Port bootA, out, 16: boot source (video ROM/RAM) read address.
REQ-015 Port bootQ, in, 8: boot source data, valid one cycle after bootA.
REQ-016 Port bootDone, out, 1: boot copy finished.
REQ-017 Port sdrRd, out, 1: one-cycle read command strobe to the SDRAM controller.
REQ-018 Port sdrWr, out, 1: one-cycle write command strobe to the SDRAM controller.
REQ-019 Port sdrRf, out, 1: one-cycle refresh command strobe to the SDRAM controller.
REQ-020 Port sdrA, out, 24: SDRAM command address.
REQ-021 Port sdrD, out, 16: SDRAM write data.
REQ-022 Port sdrQ, in, 16: SDRAM read data.
REQ-023 Port sdrDone, in, 1: one-cycle pulse when the issued command completes.
REQ-024 Port err, out, 1: sticky timeout flag.

Function
REQ-025 State set SHALL be WRDY, BRD, BWR, BWT, BRF, IDLE, CPU, RF.
- At most one of sdrRd/sdrWr/sdrRf SHALL be high in any cycle.
- Each command strobe SHALL be high for exactly one cycle, on entry to the matching wait state.
REQ-026 WRDY SHALL hold until ready=1, then go to BRD with bootA=0.
REQ-027 BRD SHALL present bootA, wait one cycle for bootQ, then go to BWR.
REQ-028 BWR SHALL issue sdrWr with sdrA={8'h00,bootA} and sdrD={bootQ,bootQ}, then go to BWT.
REQ-029 On sdrDone in BWT, if bootA==BOOTN-1 the block SHALL set bootDone=1 and go to IDLE; otherwise it SHALL increment bootA and go to BRD.
REQ-030 During boot, a cycle counter SHALL reach RFPER-1 and set a refresh-due flag.
- The flag SHALL be serviced in BRF (issue sdrRf, wait sdrDone) before the next BRD.
- The counter SHALL reset to 0 when the refresh is issued.
REQ-031 cpuReq and rfReq SHALL be ignored until bootDone=1.
- Requests arriving during boot SHALL NOT be latched.
REQ-032 rfReq high in any cycle after boot SHALL set a pending flag; multiple rfReq pulses while pending SHALL collapse to one refresh.
REQ-033 A CPU access SHALL start only on a rising edge of cpuReq (registered previous value).
- The start SHALL be latched as cpuPend together with cpuA/cpuD/cpuWe.
- A held cpuReq SHALL NOT start a second access.
REQ-034 IDLE priority: refresh pending > cpuPend.
- If both are set in the same cycle, RF is taken first and CPU follows in the next IDLE cycle.
REQ-035 CPU state SHALL issue sdrRd or sdrWr with sdrA=latched cpuA and sdrD={cpuD,cpuD}.
- On sdrDone it SHALL latch cpuQ=sdrQ[7:0] (reads only; writes leave cpuQ unchanged).
- It SHALL pulse cpuAck for one cycle in the sdrDone cycle +1 and return to IDLE.
REQ-036 RF state SHALL issue sdrRf, clear the refresh-pending flag at issue, wait for sdrDone, then return to IDLE.
- An rfReq arriving during RF SHALL re-set the pending flag.
REQ-037 In BWT, BRF, CPU and RF, a wait counter SHALL run from the strobe.
- If sdrDone has not arrived after TMO cycles, the block SHALL set err=1 and proceed as though sdrDone had occurred.
- On a CPU read timeout, cpuQ SHALL be set to 8'hFF.
REQ-038 sdrDone outside a wait state SHALL be ignored.
REQ-039 A boot address wrap beyond BOOTN-1 SHALL NOT occur; bootA SHALL hold its final value after bootDone.

Reset
REQ-040 On reset=1 at a clock edge, the block SHALL go to WRDY.
REQ-041 On reset, these outputs and flags SHALL take these values:
- sdrRd/sdrWr/sdrRf/cpuAck/bootDone/err = 0
- cpuQ = 8'hFF
- bootA/sdrA/sdrD = 0
- counters, pending flags and the registered cpuReq = 0
REQ-042 Reset mid-operation SHALL abandon the operation without a further strobe, and the boot copy SHALL restart from bootA=0 once ready=1.

Verification
REQ-043 BOOTN=4, sdrDone 3 cycles after each strobe, bootQ=8'hA0+bootA -> writes to addresses 0..3 with sdrD=A0A0..A3A3, then bootDone=1.
REQ-044 RFPER=8, BOOTN=16 -> an sdrRf is interleaved between copies roughly every 8 cycles; no two strobes are ever high together.
REQ-045 After boot, cpuReq rises with cpuWe=0, cpuA=24'h012345, sdrQ=16'h5A5A -> sdrRd with sdrA=012345, then cpuAck one cycle with cpuQ=8'h5A; cpuReq held high 20 cycles gives no second access.
REQ-046 rfReq and a cpuReq rising edge in the same cycle -> sdrRf first, then sdrRd after its sdrDone; three rfReq pulses during RF give exactly one extra refresh.
REQ-047 sdrDone withheld on a CPU read -> after TMO cycles, err=1, cpuAck pulses and cpuQ=8'hFF.
REQ-048 Reset asserted in BWT at bootA=2 -> all strobes 0 next cycle; after ready=1 the copy restarts at bootA=0.
